// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the queued SRAM responder: FSM encoding, entry field widths, defaults.
package data_sram_resp_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DELAY_DEF  = 0;
    localparam int DEPTH_DEF  = 2;

    localparam int DATA_W = 32;
    localparam int WEN_W  = 4;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/data_sram_resp_if.sv
// Initiator request/response bus plus the synchronous RAM port of data_sram_resp.
interface data_sram_resp_if #(
    parameter int ADDR_W = 16
);
    import data_sram_resp_pkg::*;

    logic              data_req;
    logic              data_wr;
    logic [WEN_W-1:0]  data_wen;
    logic [31:0]       data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              ram_en;
    logic [WEN_W-1:0]  ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output data_req, data_wr, data_wen, data_addr, data_wdata, ram_rdata,
        input  data_addr_ok, data_data_ok, data_rdata, ram_en, ram_wen, ram_addr, ram_wdata
    );

    modport slave (
        input  data_req, data_wr, data_wen, data_addr, data_wdata, ram_rdata,
        output data_addr_ok, data_data_ok, data_rdata, ram_en, ram_wen, ram_addr, ram_wdata
    );

endinterface

// File: rtl/sram_req_fifo.sv
// Generic request queue with wrap-around pointers and occupancy count.
// Latency: pushed entry visible at head the cycle after push when empty.
// Backpressure: push ignored when full, pop ignored when empty.
module sram_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Queues initiator requests and serves them in order against a synchronous RAM.
// Latency: accept in cycle N -> data_data_ok in N+3+DELAY; back-to-back every 2+DELAY.
// Backpressure: data_addr_ok drops while the queue holds DEPTH entries.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DELAY  = DELAY_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input logic             clk,
    input logic             resetn,
    data_sram_resp_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = (DELAY > 0) ? WAIT_W'(DELAY - 1) : '0;

    typedef struct packed {
        logic              wr;
        logic [WEN_W-1:0]  wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t            push_dat;
    entry_t            head;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              unused_addr_bits;

    // Gating with resetn keeps addr_ok low even if data_req is held during reset.
    assign bus.data_addr_ok = bus.data_req & ~full & resetn;
    assign push             = bus.data_req & bus.data_addr_ok;
    assign pop              = (state == ST_RESP);
    assign push_dat         = '{wr:    bus.data_wr,
                                wen:   bus.data_wen,
                                addr:  bus.data_addr[ADDR_W+1:2],
                                wdata: bus.data_wdata};
    assign unused_addr_bits = ^{bus.data_addr[1:0], bus.data_addr >> (ADDR_W + 2)};

    sram_req_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        wait_cnt_nxt      = wait_cnt;
        bus.ram_en        = 1'b0;
        bus.ram_wen       = '0;
        bus.ram_addr      = '0;
        bus.ram_wdata     = '0;
        bus.data_data_ok  = 1'b0;
        bus.data_rdata    = '0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    if (DELAY > 0) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) state_nxt = ST_ACCESS;
                else                wait_cnt_nxt = wait_cnt - WAIT_W'(1);
            end
            ST_ACCESS: begin
                bus.ram_en    = 1'b1;
                bus.ram_addr  = head.addr;
                bus.ram_wdata = head.wdata;
                bus.ram_wen   = head.wr ? head.wen : '0;
                state_nxt     = ST_RESP;
            end
            ST_RESP: begin
                bus.data_data_ok = 1'b1;
                bus.data_rdata   = head.wr ? '0 : bus.ram_rdata;
                // Occupancy after this cycle's pop and any simultaneous push.
                if (count > CNT_W'(1) || push) begin
                    if (DELAY > 0) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = ST_ACCESS;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench: two responders (DELAY 0 and 3) against a word-level memory reference model.
module tb_data_sram_resp;
    import data_sram_resp_pkg::*;

    localparam int DEP  = 2;
    localparam int DLY0 = 0;
    localparam int DLY1 = 3;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [3:0]  wen;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [2];
    logic        req [2];
    logic        wr [2];
    logic [3:0]  wen [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        aok [2];
    logic        dok [2];
    logic [31:0] rdata [2];
    logic        ram_en [2];
    logic [3:0]  ram_wen [2];
    logic [15:0] ram_addr [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rd0;
    logic [31:0] ram_rd1;

    data_sram_resp_if #(.ADDR_W(16)) bus0 ();
    data_sram_resp_if #(.ADDR_W(16)) bus1 ();

    assign bus0.data_req   = req[0];
    assign bus0.data_wr    = wr[0];
    assign bus0.data_wen   = wen[0];
    assign bus0.data_addr  = addr[0];
    assign bus0.data_wdata = wdata[0];
    assign bus0.ram_rdata  = ram_rd0;
    assign aok[0]          = bus0.data_addr_ok;
    assign dok[0]          = bus0.data_data_ok;
    assign rdata[0]        = bus0.data_rdata;
    assign ram_en[0]       = bus0.ram_en;
    assign ram_wen[0]      = bus0.ram_wen;
    assign ram_addr[0]     = bus0.ram_addr;
    assign ram_wdata[0]    = bus0.ram_wdata;

    assign bus1.data_req   = req[1];
    assign bus1.data_wr    = wr[1];
    assign bus1.data_wen   = wen[1];
    assign bus1.data_addr  = addr[1];
    assign bus1.data_wdata = wdata[1];
    assign bus1.ram_rdata  = ram_rd1;
    assign aok[1]          = bus1.data_addr_ok;
    assign dok[1]          = bus1.data_data_ok;
    assign rdata[1]        = bus1.data_rdata;
    assign ram_en[1]       = bus1.ram_en;
    assign ram_wen[1]      = bus1.ram_wen;
    assign ram_addr[1]     = bus1.ram_addr;
    assign ram_wdata[1]    = bus1.ram_wdata;

    data_sram_resp #(.ADDR_W(16), .DELAY(DLY0), .DEPTH(DEP)) u_dut0 (
        .clk    (clk),
        .resetn (rstn[0]),
        .bus    (bus0)
    );

    data_sram_resp #(.ADDR_W(16), .DELAY(DLY1), .DEPTH(DEP)) u_dut1 (
        .clk    (clk),
        .resetn (rstn[1]),
        .bus    (bus1)
    );

    int passed = 0;
    int total  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req_v);
        total++;
        if (act === req_v) passed++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, req_v);
    endfunction

    function automatic logic [31:0] init_val(int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'hAABBCCDD;
        return {8'(i), 8'(~i), 8'(i * 7), 8'h5A};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Synchronous RAMs: one-cycle read latency, byte-enabled writes.
    logic [31:0] ram0 [256];
    logic [31:0] ram1 [256];
    logic        ld0 = 1'b0;
    logic        ld1 = 1'b0;

    always @(posedge clk) begin
        if (!ld0) begin
            for (int i = 0; i < 256; i++) ram0[i] <= init_val(i);
            ld0 <= 1'b1;
        end else if (ram_en[0]) begin
            ram_rd0 <= ram0[ram_addr[0][7:0]];
            ram0[ram_addr[0][7:0]] <= merge(ram0[ram_addr[0][7:0]], ram_wdata[0], ram_wen[0]);
        end
    end

    always @(posedge clk) begin
        if (!ld1) begin
            for (int i = 0; i < 256; i++) ram1[i] <= init_val(i);
            ld1 <= 1'b1;
        end else if (ram_en[1]) begin
            ram_rd1 <= ram1[ram_addr[1][7:0]];
            ram1[ram_addr[1][7:0]] <= merge(ram1[ram_addr[1][7:0]], ram_wdata[1], ram_wen[1]);
        end
    end

    // Reference model: memory image, expected responses in acceptance order, occupancy.
    logic [31:0] ref_mem [2][256];
    exp_t        exp_q [2][$];
    int          outst [2];
    int          last_resp [2];
    bit          ref_ld = 1'b0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(int k);
        exp_t       e;
        logic [7:0] idx;
        int         d;
        d = (k == 0) ? DLY0 : DLY1;
        if (!rstn[k]) begin
            exp_q[k].delete();
            outst[k]     = 0;
            last_resp[k] = -100;
            chk("reset_outputs", 32'({aok[k], dok[k], ram_en[k], ram_wen[k]}) | rdata[k]
                | ram_wdata[k] | 32'(ram_addr[k]), 32'h0);
            return;
        end
        chk("addr_ok", 32'(aok[k]), 32'(req[k] && outst[k] < DEP));
        if (ram_en[k]) begin
            if (exp_q[k].size() == 0) begin
                chk("ram_en_unexpected", 32'(ram_en[k]), 32'h0);
            end else begin
                e = exp_q[k][0];
                chk("ram_cycle", cyc, e.cyc - 1);
                chk("ram_addr", 32'(ram_addr[k]), 32'(e.addr));
                chk("ram_wen", 32'(ram_wen[k]), e.wr ? 32'(e.wen) : 32'h0);
                if (e.wr) chk("ram_wdata", ram_wdata[k], e.wdata);
            end
        end else begin
            chk("idle_ram_wen", 32'(ram_wen[k]), 32'h0);
        end
        if (dok[k]) begin
            if (exp_q[k].size() == 0) begin
                chk("resp_unexpected", 32'(dok[k]), 32'h0);
            end else begin
                e = exp_q[k].pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_rdata", rdata[k], e.rdata);
                outst[k]--;
            end
        end else begin
            chk("idle_rdata", rdata[k], 32'h0);
        end
        if (req[k] && aok[k]) begin
            e.wr    = wr[k];
            e.wen   = wen[k];
            e.addr  = addr[k][17:2];
            e.wdata = wdata[k];
            idx     = addr[k][9:2];
            if (wr[k]) begin
                ref_mem[k][idx] = merge(ref_mem[k][idx], wdata[k], wen[k]);
                e.rdata = 32'h0;
            end else begin
                e.rdata = ref_mem[k][idx];
            end
            // Idle responder: 3+D after acceptance; otherwise 2+D after the previous response.
            e.cyc        = (cyc > last_resp[k]) ? cyc + 3 + d : last_resp[k] + 2 + d;
            last_resp[k] = e.cyc;
            outst[k]++;
            exp_q[k].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!ref_ld) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 256; i++) ref_mem[k][i] = init_val(i);
            ref_ld = 1'b1;
        end
        for (int k = 0; k < 2; k++) mon(k);
    end

    task automatic issue(int k, logic w, logic [3:0] be, logic [31:0] a, logic [31:0] d);
        int n = 0;
        req[k]   = 1'b1;
        wr[k]    = w;
        wen[k]   = be;
        addr[k]  = a;
        wdata[k] = d;
        do begin
            @(negedge clk);
            n++;
        end while (!aok[k] && n < 100);
        if (!aok[k]) chk("accept_timeout", 32'(aok[k]), 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k, int n);
        req[k] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(int k);
        int n = 0;
        req[k] = 1'b0;
        while (exp_q[k].size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q[k].size(), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(int k, int n);
        logic       w;
        logic [3:0] be;
        int         gap;
        for (int i = 0; i < n; i++) begin
            w   = 1'($urandom_range(0, 1));
            be  = 4'($urandom_range(0, 15));
            issue(k, w, be, 32'($urandom_range(0, 1023)), $urandom);
            gap = $urandom_range(0, 5);
            if (gap > 3) gap = 0;
            idle(k, gap);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstn[k]  = 1'b0;
            req[k]   = 1'b0;
            wr[k]    = 1'b0;
            wen[k]   = 4'h0;
            addr[k]  = 32'h0;
            wdata[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        idle(0, 2);

        // Single read of word 4, then write/read-back of word 8, then a no-byte write to word 16.
        issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        drain(0);
        issue(0, 1'b1, 4'b0011, 32'h0000_0020, 32'h1122_3344);
        issue(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
        drain(0);
        chk("ram_word8_merged", ram0[8], 32'hAABB_3344);
        issue(0, 1'b1, 4'b0000, 32'h0000_0040, 32'hFFFF_FFFF);
        drain(0);
        chk("ram_word16_unchanged", ram0[16], init_val(16));

        // Four requests with data_req held high across a full queue.
        issue(0, 1'b1, 4'hF, 32'h0000_0080, 32'h0102_0304);
        issue(0, 1'b0, 4'h0, 32'h0000_0080, 32'h0);
        issue(0, 1'b1, 4'b1100, 32'h0000_0084, 32'hCAFE_F00D);
        issue(0, 1'b0, 4'h0, 32'h0000_0086, 32'h0);
        drain(0);

        rand_run(0, 200);
        drain(0);

        issue(1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        drain(1);
        rand_run(1, 60);
        drain(1);

        // Reset while the first of two queued reads is waiting.
        issue(1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        issue(1, 1'b0, 4'h0, 32'h0000_0024, 32'h0);
        rstn[1] = 1'b0;
        #1;
        chk("rst_addr_ok", 32'(aok[1]), 32'h0);
        chk("rst_data_ok", 32'(dok[1]), 32'h0);
        chk("rst_ram_en", 32'(ram_en[1]), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn[1] = 1'b1;
        idle(1, 12);
        issue(1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
        drain(1);

        idle(0, 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
